gb_cpu_bus_bridge: RTL

//  Upstream neighbour of the system memory bus. Turns the CPU's one-at-a-time byte accesses into

---
 rtl/gb_bus_pkg.sv | 17 +
 rtl/gb_bus_watchdog.sv | 50 +++++
 rtl/gb_cpu_bus_bridge.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared types and constants for the Game Boy system memory bus
package gb_bus_pkg;

    localparam int GB_ADDR_W = 16;
    localparam int GB_DATA_W = 8;

    // Value returned to the CPU when nothing drives the bus (error, timeout, retry abort)
    localparam logic [GB_DATA_W-1:0] OPEN_BUS_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        BACKOFF
    } bridge_state_t;

endpackage

// File: rtl/gb_bus_watchdog.sv
// rtl/gb_bus_watchdog.sv - response timeout and retry-limit counters for a bus initiator
module gb_bus_watchdog #(
    parameter int TimeoutCycles = 256,
    parameter int MaxRetries    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clearAll,
    input  logic clearTimeout,
    input  logic waitTick,
    input  logic retryTick,
    output logic timeoutDue,
    output logic retryLimitDue
);

    localparam int ToW = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCycles - 1);
    localparam logic [7:0] RetryLimit = 8'(MaxRetries);

    logic [ToW-1:0] toCnt;
    logic [7:0]     retryCnt;
    logic [7:0]     retryNext;

    // Saturating retry increment; the limit is judged on the count this RTY would produce
    assign retryNext     = (retryCnt == 8'hFF) ? retryCnt : retryCnt + 8'd1;
    assign retryLimitDue = (MaxRetries != 0) && (retryNext == RetryLimit);

    // The current silent WAIT cycle is the last one allowed
    assign timeoutDue    = (TimeoutCycles != 0) && (toCnt == ToLast);

    // Both counters saturate; timeout restarts on every strobe accept, retries only per access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toCnt    <= '0;
            retryCnt <= '0;
        end else begin
            if (clearAll || clearTimeout) begin
                toCnt <= '0;
            end else if (waitTick && (toCnt != {ToW{1'b1}})) begin
                toCnt <= toCnt + ToW'(1);
            end
            if (clearAll) begin
                retryCnt <= '0;
            end else if (retryTick) begin
                retryCnt <= retryNext;
            end
        end
    end

endmodule

// File: rtl/gb_cpu_bus_bridge.sv
// rtl/gb_cpu_bus_bridge.sv - CPU byte access to pipelined Wishbone bridge with retry and timeout
module gb_cpu_bus_bridge
    import gb_bus_pkg::*;
#(
    parameter int TimeoutCycles = 256,
    parameter int RetryDelay    = 1,
    parameter int MaxRetries    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpuReq,
    input  logic [GB_ADDR_W-1:0] cpuAddr,
    input  logic                 cpuWe,
    input  logic [GB_DATA_W-1:0] cpuWData,
    output logic [GB_DATA_W-1:0] cpuRData,
    output logic                 cpuDone,
    output logic                 cpuErr,
    output logic                 cpuHold,
    output logic                 memCyc,
    output logic                 memStb,
    output logic                 memWe,
    output logic [GB_ADDR_W-1:0] memAddr,
    output logic [GB_DATA_W-1:0] memDatToTarget,
    input  logic [GB_DATA_W-1:0] memDatToInitiator,
    input  logic                 memAck,
    input  logic                 memErr,
    input  logic                 memRty,
    input  logic                 memStall
);

    localparam int BoW = (RetryDelay < 2) ? 1 : $clog2(RetryDelay);
    localparam logic [BoW-1:0] BoLast = BoW'(RetryDelay - 1);

    bridge_state_t        state, stateNext;
    logic                 cycNext, stbNext, weNext, doneNext, errNext;
    logic [GB_ADDR_W-1:0] addrNext;
    logic [GB_DATA_W-1:0] datNext, rdataNext;
    logic [BoW-1:0]       boCnt, boCntNext;
    logic                 abortNow;
    logic                 wdClearAll, wdClearTimeout, wdWaitTick, wdRetryTick;
    logic                 timeoutDue, retryLimitDue;

    gb_bus_watchdog #(
        .TimeoutCycles(TimeoutCycles),
        .MaxRetries   (MaxRetries)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .clearAll     (wdClearAll),
        .clearTimeout (wdClearTimeout),
        .waitTick     (wdWaitTick),
        .retryTick    (wdRetryTick),
        .timeoutDue   (timeoutDue),
        .retryLimitDue(retryLimitDue)
    );

    // The CPU must freeze in the very cycle it raises a request
    assign cpuHold = (state != IDLE) | cpuReq;

    // State, bus-facing latches and CPU result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            memCyc         <= 1'b0;
            memStb         <= 1'b0;
            memWe          <= 1'b0;
            memAddr        <= '0;
            memDatToTarget <= '0;
            cpuRData       <= OPEN_BUS_DATA;
            cpuDone        <= 1'b0;
            cpuErr         <= 1'b0;
            boCnt          <= '0;
        end else begin
            state          <= stateNext;
            memCyc         <= cycNext;
            memStb         <= stbNext;
            memWe          <= weNext;
            memAddr        <= addrNext;
            memDatToTarget <= datNext;
            cpuRData       <= rdataNext;
            cpuDone        <= doneNext;
            cpuErr         <= errNext;
            boCnt          <= boCntNext;
        end
    end

    // Next-state and next-output decode; response priority in WAIT is ERR > RTY > ACK
    always_comb begin
        stateNext      = state;
        cycNext        = memCyc;
        stbNext        = memStb;
        weNext         = memWe;
        addrNext       = memAddr;
        datNext        = memDatToTarget;
        rdataNext      = cpuRData;
        doneNext       = 1'b0;
        errNext        = 1'b0;
        boCntNext      = boCnt;
        abortNow       = 1'b0;
        wdClearAll     = 1'b0;
        wdClearTimeout = 1'b0;
        wdWaitTick     = 1'b0;
        wdRetryTick    = 1'b0;

        case (state)
            IDLE: begin
                if (cpuReq) begin
                    addrNext   = cpuAddr;
                    weNext     = cpuWe;
                    datNext    = cpuWData;
                    cycNext    = 1'b1;
                    stbNext    = 1'b1;
                    wdClearAll = 1'b1;
                    stateNext  = REQ;
                end
            end
            REQ: begin
                if (!memStall) begin
                    stbNext        = 1'b0;
                    wdClearTimeout = 1'b1;
                    stateNext      = WAIT;
                end
            end
            WAIT: begin
                if (memErr) begin
                    abortNow = 1'b1;
                end else if (memRty) begin
                    wdRetryTick = 1'b1;
                    if (retryLimitDue) begin
                        abortNow = 1'b1;
                    end else if (RetryDelay == 0) begin
                        stbNext   = 1'b1;
                        stateNext = REQ;
                    end else begin
                        cycNext   = 1'b0;
                        boCntNext = '0;
                        stateNext = BACKOFF;
                    end
                end else if (memAck) begin
                    if (!memWe) begin
                        rdataNext = memDatToInitiator;
                    end
                    doneNext  = 1'b1;
                    cycNext   = 1'b0;
                    stateNext = IDLE;
                end else begin
                    wdWaitTick = 1'b1;
                    if (timeoutDue) begin
                        abortNow = 1'b1;
                    end
                end
            end
            BACKOFF: begin
                if (boCnt == BoLast) begin
                    cycNext   = 1'b1;
                    stbNext   = 1'b1;
                    stateNext = REQ;
                end else begin
                    boCntNext = boCnt + BoW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        if (abortNow) begin
            rdataNext = OPEN_BUS_DATA;
            doneNext  = 1'b1;
            errNext   = 1'b1;
            cycNext   = 1'b0;
            stbNext   = 1'b0;
            stateNext = IDLE;
        end
    end

    // Target responses outside WAIT mean the target broke the handshake
    always @(posedge clk) begin
        if (!rst && (state != WAIT)) begin
            assert (!(memAck || memErr || memRty));
        end
    end

endmodule
